fft_r4_16p_reorder: RTL and testbench

Output reorder buffer placed directly downstream of the radix-4 16-point FFT core. It captures the core's four parallel complex outputs per cycle, which arrive in digit-reversed order across four consecutive valid beats. It then emits the frame serially in natural bin order 0..15 over a valid/ready stream. A ping-pong pair of 16-entry banks lets one frame drain while the next fills.

---
 rtl/fft_reorder_pkg.sv | 22 ++
 rtl/fft_reorder_bank.sv | 34 +++
 rtl/fft_r4_16p_reorder.sv | 182 ++++++++++++++++++
 tb/tb_fft_r4_16p_reorder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_reorder_pkg.sv
// Shared constants, writer state encoding and the digit-reversal address map
// for the radix-4 16-point FFT output reorder buffer.
package fft_reorder_pkg;

    localparam int N      = 16;
    localparam int LANES  = 4;
    localparam int GROUPS = 4;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } wr_state_t;

    // Lane k of group g carries bin 4*k+g.
    function automatic logic [ADDR_W-1:0] bin_addr(input logic [1:0] group,
                                                   input logic [1:0] lane);
        return {lane, group};
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// 16-entry complex register bank: one 4-lane group write per cycle scattered
// to digit-reversed addresses, one combinational read port.
module fft_reorder_bank
    import fft_reorder_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [1:0]                 wgroup,
    input  logic [LANES-1:0][DW-1:0]   wre,
    input  logic [LANES-1:0][DW-1:0]   wim,
    input  logic [ADDR_W-1:0]          raddr,
    output logic [DW-1:0]              rre,
    output logic [DW-1:0]              rim
);

    logic [N-1:0][DW-1:0] mem_re;
    logic [N-1:0][DW-1:0] mem_im;

    // Contents are deliberately not reset; the full flags gate visibility.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < LANES; k++) begin
                mem_re[bin_addr(wgroup, 2'(k))] <= wre[k];
                mem_im[bin_addr(wgroup, 2'(k))] <= wim[k];
            end
        end
    end

    assign rre = mem_re[raddr];
    assign rim = mem_im[raddr];

endmodule

// File: rtl/fft_r4_16p_reorder.sv
// Ping-pong reorder buffer: captures digit-reversed 4-lane FFT groups and
// streams bins 0..15 in natural order. Optional 1/16 output scaling with
// round-half-up is enabled by defining FFT_REORDER_SCALE_EN.
module fft_r4_16p_reorder
    import fft_reorder_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_0_real,
    input  logic [DW-1:0] in_0_im,
    input  logic [DW-1:0] in_1_real,
    input  logic [DW-1:0] in_1_im,
    input  logic [DW-1:0] in_2_real,
    input  logic [DW-1:0] in_2_im,
    input  logic [DW-1:0] in_3_real,
    input  logic [DW-1:0] in_3_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_im,
    output logic [3:0]    out_index,
    output logic          out_sof,
    output logic          out_eof,
    output logic          overflow
);

    logic [LANES-1:0][DW-1:0] lane_re, lane_im;
    assign lane_re = {in_3_real, in_2_real, in_1_real, in_0_real};
    assign lane_im = {in_3_im,   in_2_im,   in_1_im,   in_0_im};

    wr_state_t         state;
    logic [1:0]        grp;
    logic [1:0]        drop_cnt;
    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        full;
    logic [ADDR_W-1:0] rd_idx;

    logic              wr_en;
    logic [1:0]        wr_grp;
    logic              rd_fire;
    logic              rd_last;

    // Write decode; an sof inside FILL restarts the same bank at group 0.
    always_comb begin
        wr_en  = 1'b0;
        wr_grp = grp;
        case (state)
            IDLE: begin
                if (in_valid && in_sof && !full[wr_bank]) begin
                    wr_en  = 1'b1;
                    wr_grp = 2'd0;
                end
            end
            FILL: begin
                if (in_valid) begin
                    wr_en  = 1'b1;
                    wr_grp = in_sof ? 2'd0 : grp;
                end
            end
            default: ;
        endcase
    end

    assign out_valid = full[rd_bank];
    assign rd_fire   = out_valid && out_ready;
    assign rd_last   = (rd_idx == ADDR_W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grp      <= 2'd0;
            drop_cnt <= 2'd0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full     <= 2'b00;
            rd_idx   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_sof) begin
                        if (full[wr_bank]) begin
                            overflow <= 1'b1;
                            drop_cnt <= 2'd3;
                            state    <= DROP;
                        end else begin
                            grp   <= 2'd1;
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            grp <= 2'd1;
                        end else if (grp == 2'd3) begin
                            full[wr_bank] <= 1'b1;
                            wr_bank       <= ~wr_bank;
                            state         <= IDLE;
                        end else begin
                            grp <= grp + 2'd1;
                        end
                    end
                end
                DROP: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            drop_cnt <= 2'd3;
                        end else if (drop_cnt == 2'd1) begin
                            state <= IDLE;
                        end else begin
                            drop_cnt <= drop_cnt - 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Reader only ever clears the full bank it is draining, which the
            // writer never targets while filling, so the two updates are disjoint.
            if (rd_fire) begin
                if (rd_last) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    rd_idx        <= '0;
                end else begin
                    rd_idx <= rd_idx + ADDR_W'(1);
                end
            end
        end
    end

    logic [1:0][DW-1:0] bk_re, bk_im;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_reorder_bank #(.DW(DW)) u_bank (
            .clk    (clk),
            .we     (wr_en && (wr_bank == 1'(b))),
            .wgroup (wr_grp),
            .wre    (lane_re),
            .wim    (lane_im),
            .raddr  (rd_idx),
            .rre    (bk_re[b]),
            .rim    (bk_im[b])
        );
    end

    logic [DW-1:0] sel_re, sel_im;
    assign sel_re = bk_re[rd_bank];
    assign sel_im = bk_im[rd_bank];

`ifdef FFT_REORDER_SCALE_EN
    // Widened by one bit so the +8 rounding offset cannot wrap.
    function automatic logic [DW-1:0] scale16(input logic [DW-1:0] x);
        logic signed [DW:0] t;
        logic signed [DW:0] s;
        t = $signed({x[DW-1], x}) + $signed((DW+1)'(8));
        s = t >>> 4;
        return s[DW-1:0];
    endfunction

    logic [DW-1:0] res_re, res_im;
    assign res_re = scale16(sel_re);
    assign res_im = scale16(sel_im);
`else
    logic [DW-1:0] res_re, res_im;
    assign res_re = sel_re;
    assign res_im = sel_im;
`endif

    assign out_real  = out_valid ? res_re : '0;
    assign out_im    = out_valid ? res_im : '0;
    assign out_index = out_valid ? rd_idx : '0;
    assign out_sof   = out_valid && (rd_idx == '0);
    assign out_eof   = out_valid && rd_last;

endmodule

// File: tb/tb_fft_r4_16p_reorder.sv
// Directed scoreboard bench for the FFT output reorder buffer; expected bins
// are queued as frames are driven and popped as the DUT transfers them.
module tb_fft_r4_16p_reorder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_sof;
    logic [31:0] in_0_real, in_0_im, in_1_real, in_1_im;
    logic [31:0] in_2_real, in_2_im, in_3_real, in_3_im;
    logic        out_valid, out_ready;
    logic [31:0] out_real, out_im;
    logic [3:0]  out_index;
    logic        out_sof, out_eof, overflow;

    fft_r4_16p_reorder #(.DW(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
        .in_0_real(in_0_real), .in_0_im(in_0_im),
        .in_1_real(in_1_real), .in_1_im(in_1_im),
        .in_2_real(in_2_real), .in_2_im(in_2_im),
        .in_3_real(in_3_real), .in_3_im(in_3_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_im(out_im), .out_index(out_index),
        .out_sof(out_sof), .out_eof(out_eof), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic [3:0]  idx;
    } exp_t;

    exp_t q[$];
    int   frm[16];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl(input int v);
`ifdef FFT_REORDER_SCALE_EN
        longint t;
        t = longint'(v) + 64'sd8;
        return 32'(t >>> 4);
`else
        return 32'(v);
`endif
    endfunction

    task automatic push_frm();
        for (int i = 0; i < 16; i++)
            q.push_back('{re: mdl(frm[i]), im: mdl(-frm[i]), idx: 4'(i)});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_group(input int g, input logic sof);
        in_valid  = 1'b1;
        in_sof    = sof;
        in_0_real = frm[g];      in_0_im = -frm[g];
        in_1_real = frm[4 + g];  in_1_im = -frm[4 + g];
        in_2_real = frm[8 + g];  in_2_im = -frm[8 + g];
        in_3_real = frm[12 + g]; in_3_im = -frm[12 + g];
        cyc(1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frm();
        for (int g = 0; g < 4; g++) send_group(g, g == 0);
    endtask

    task automatic set_frm(input int off);
        for (int i = 0; i < 16; i++) frm[i] = i + off;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_real"},  out_real, 32'd0);
        chk({tag, "_im"},    out_im, 32'd0);
        chk({tag, "_index"}, {28'd0, out_index}, 32'd0);
        chk({tag, "_sof"},   {31'd0, out_sof}, 32'd0);
        chk({tag, "_eof"},   {31'd0, out_eof}, 32'd0);
        chk({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
    endtask

    // Scoreboard consumer: every accepted bin must match the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("bin_real",  out_real, e.re);
                chk("bin_im",    out_im, e.im);
                chk("bin_index", {28'd0, out_index}, {28'd0, e.idx});
                chk("bin_sof",   {31'd0, out_sof}, {31'd0, e.idx == 4'd0});
                chk("bin_eof",   {31'd0, out_eof}, {31'd0, e.idx == 4'd15});
            end
        end
    end

    initial begin
        logic found;
        logic [31:0] held_re;
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        in_0_real = '0; in_0_im = '0; in_1_real = '0; in_1_im = '0;
        in_2_real = '0; in_2_im = '0; in_3_real = '0; in_3_im = '0;
        cyc(2);
        chk_idle_outputs("reset");
        reset = 1'b0;
        cyc(1);

        // Single frame with latency check around the group-3 beat
        set_frm(0);
        push_frm();
        send_group(0, 1'b1);
        send_group(1, 1'b0);
        send_group(2, 1'b0);
        chk("lat_pre_valid", {31'd0, out_valid}, 32'd0);
        send_group(3, 1'b0);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_index", {28'd0, out_index}, 32'd0);
        wait_drain();
        cyc(2);

        // Back-to-back frames every 16 cycles must stream without a gap
        fork
            begin
                set_frm(0);
                push_frm();
                send_frm();
                cyc(12);
                set_frm(100);
                push_frm();
                send_frm();
            end
            begin
                found = 1'b0;
                for (int t = 0; t < 20 && !found; t++) begin
                    @(negedge clk);
                    found = out_valid;
                end
                chk("b2b_start", {31'd0, found}, 32'd1);
                for (int t = 0; t < 31; t++) begin
                    @(negedge clk);
                    chk("b2b_gap", {31'd0, out_valid}, 32'd1);
                end
            end
        join
        wait_drain();
        chk("b2b_ovf", {31'd0, overflow}, 32'd0);
        cyc(2);

        // Backpressure: A and B buffered, C dropped with overflow
        out_ready = 1'b0;
        set_frm(200); push_frm(); send_frm();
        set_frm(300); push_frm(); send_frm();
        chk("ovf_before_c", {31'd0, overflow}, 32'd0);
        set_frm(400);
        send_group(0, 1'b1);
        chk("ovf_on_c_sof", {31'd0, overflow}, 32'd1);
        send_group(1, 1'b0);
        send_group(2, 1'b0);
        send_group(3, 1'b0);
        held_re = out_real;
        cyc(3);
        chk("stall_real",   out_real, held_re);
        chk("stall_real_a", out_real, mdl(200));
        chk("stall_index",  {28'd0, out_index}, 32'd0);
        out_ready = 1'b1;
        wait_drain();
        cyc(3);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Resync: partial frame abandoned by a new sof, then a stray beat
        set_frm(500);
        send_group(0, 1'b1);
        send_group(1, 1'b0);
        set_frm(600); push_frm(); send_frm();
        wait_drain();
        cyc(2);
        set_frm(900);
        send_group(1, 1'b0);
        cyc(25);
        chk("stray_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of draining
        set_frm(700); push_frm(); send_frm();
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            found = out_valid && (out_index == 4'd7);
        end
        chk("idx7_seen", {31'd0, found}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        chk_idle_outputs("mid_reset");
        reset = 1'b0;
        cyc(1);
        set_frm(800); push_frm(); send_frm();
        wait_drain();
        cyc(2);

        // Rounding corner values (pass through unless scaling is built in)
        set_frm(0);
        for (int i = 0; i < 16; i++) frm[i] = 0;
        frm[0] = 16; frm[1] = 24; frm[2] = -24; frm[3] = 7;
        push_frm(); send_frm();
        wait_drain();
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
